// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for four cores: GRANT, SNOOP window, DATA, DONE.
// Optional DATA-state watchdog is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int SNOOP_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] req_type,
  input  logic       mem_done,
  output logic [3:0] gnt,
  output logic [1:0] proc_ID,
  output logic       RdMs,
  output logic       WrMs,
  output logic       WrBk,
  output logic       busy,
  output logic       txn_done,
  output logic       err
);

  if (SNOOP_CYCLES < 1 || SNOOP_CYCLES > 15 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, GRANT, SNOOP, DATA, DONE
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [3:0] snoop_cnt;
  logic [3:0] elig;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic [1:0] cmd;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++)
      elig[i] = req[i] && (req_type[2*i +: 2] != 2'b11);
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    cmd = req_type[2*win +: 2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      snoop_cnt <= 4'd0;
      gnt       <= 4'd0;
      proc_ID   <= 2'd0;
      RdMs      <= 1'b0;
      WrMs      <= 1'b0;
      WrBk      <= 1'b0;
      busy      <= 1'b0;
      txn_done  <= 1'b0;
      err       <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt    <= 8'd0;
`endif
    end else begin
      txn_done <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            gnt     <= 4'b0001 << win;
            proc_ID <= win;
            RdMs    <= (cmd == 2'b00);
            WrMs    <= (cmd == 2'b01);
            WrBk    <= (cmd == 2'b10);
            busy    <= 1'b1;
          end
        end
        GRANT: begin
          state     <= SNOOP;
          snoop_cnt <= 4'(SNOOP_CYCLES - 1);
        end
        SNOOP: begin
          if (snoop_cnt == 4'd0) begin
            state <= DATA;
`ifdef BUS_ARB_TIMEOUT_EN
            wd_cnt <= 8'd0;
`endif
          end else begin
            snoop_cnt <= snoop_cnt - 4'd1;
          end
        end
        DATA: begin
          if (mem_done) begin
            state    <= DONE;
            txn_done <= 1'b1;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (wd_cnt == TMO_LAST) begin
            state    <= DONE;
            txn_done <= 1'b1;
            err      <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state   <= IDLE;
          rr_ptr  <= proc_ID + 2'd1;
          gnt     <= 4'd0;
          proc_ID <= 2'd0;
          RdMs    <= 1'b0;
          WrMs    <= 1'b0;
          WrBk    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; honours BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;

  localparam int SC  = 2;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_type;
  logic       mem_done;
  logic [3:0] gnt;
  logic [1:0] proc_ID;
  logic       RdMs, WrMs, WrBk, busy, txn_done, err;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.SNOOP_CYCLES(SC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type),
    .mem_done(mem_done), .gnt(gnt), .proc_ID(proc_ID),
    .RdMs(RdMs), .WrMs(WrMs), .WrBk(WrBk), .busy(busy),
    .txn_done(txn_done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: one transaction record plus cycle age.
  bit m_act, m_done, m_err;
  int m_own, m_cmd, m_age, m_wait, m_ptr;

  task automatic m_reset();
    m_act = 0; m_done = 0; m_err = 0;
    m_own = 0; m_cmd = 0; m_age = 0; m_wait = 0; m_ptr = 0;
  endtask

  task automatic m_step();
    if (m_done) begin
      m_act = 0; m_done = 0; m_err = 0;
      m_ptr = (m_own + 1) % 4;
    end else if (m_act) begin
      if (m_age > SC) begin
        if (mem_done) m_done = 1;
        else begin
          m_wait++;
`ifdef BUS_ARB_TIMEOUT_EN
          if (m_wait == TMO) begin m_done = 1; m_err = 1; end
`endif
        end
      end
      m_age++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        int t;
        i = (m_ptr + k) % 4;
        t = (req_type >> (2 * i)) & 3;
        if (!m_act && req[i] && t != 3) begin
          m_act = 1; m_own = i; m_cmd = t; m_age = 0; m_wait = 0;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = m_act ? (4'b0001 << m_own) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("proc_ID", 32'(proc_ID), m_act ? 32'(m_own) : 32'd0);
    chk("RdMs", 32'(RdMs), 32'(m_act && m_cmd == 0));
    chk("WrMs", 32'(WrMs), 32'(m_act && m_cmd == 1));
    chk("WrBk", 32'(WrBk), 32'(m_act && m_cmd == 2));
    chk("busy", 32'(busy), 32'(m_act));
    chk("txn_done", 32'(txn_done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1 check_all();
  endtask

  // Asserted mid-cycle so the asynchronous path is what clears outputs.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    tick();
    #2 rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (m_act && m_age == 0) ok = 1;
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      if (!m_act) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int t_g, t_d, n;
    int order[$];
    int exp_order[5];

    m_reset();
    rst = 1'b1; req = '0; req_type = '0; mem_done = 1'b0;
    tick();
    #2 rst = 1'b0;

    // Single RdMs from core 0, memory already ready.
    req = 4'b0001; req_type = 8'h00; mem_done = 1'b1;
    wait_grant(10, ok);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_rd", 32'(RdMs), 32'd1);
    t_g = 0; t_d = -1;
    for (int c = 1; c < 12 && t_d < 0; c++) begin
      tick();
      if (txn_done) t_d = c;
    end
    chk("t1_latency", 32'(t_d - t_g), 32'd4);
    req = '0;
    wait_idle(10);

    // All four requesting WrMs: strict rotation.
    do_reset();
    req = 4'b1111; req_type = 8'h55; mem_done = 1'b1;
    order.delete();
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      if (m_act && m_age == 0) order.push_back(int'(proc_ID));
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("t2_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("t2_order", 32'(order[i]), 32'(exp_order[i]));
    req = '0;
    wait_idle(20);

    // Pointer at 3, cores 1 and 2 requesting; drop req during SNOOP.
    do_reset();
    req = 4'b0100; req_type = 8'h20;
    wait_grant(10, ok);
    req = '0;
    wait_idle(20);
    req = 4'b0110; req_type = 8'h00;
    wait_grant(10, ok);
    chk("t3_first", 32'(proc_ID), 32'd1);
    tick(); tick();
    req = '0;
    t_d = 0;
    for (int c = 0; c < 10 && t_d == 0; c++) begin
      tick();
      if (txn_done) t_d = 1;
    end
    chk("t3_done", 32'(t_d), 32'd1);
    wait_idle(5);
    req = 4'b0110;
    wait_grant(10, ok);
    chk("t3_second", 32'(proc_ID), 32'd2);
    req = '0;
    wait_idle(20);

    // Reserved type on core 0 is never granted.
    do_reset();
    req = 4'b0101; req_type = 8'h23;
    for (int k = 0; k < 3; k++) begin
      wait_grant(10, ok);
      chk("t4_owner", 32'(proc_ID), 32'd2);
      chk("t4_wrbk", 32'(WrBk), 32'd1);
    end
    req = '0;
    wait_idle(20);

    // Reset in DATA aborts; next grant restarts at core 0.
    do_reset();
    req = 4'b1000; req_type = 8'h00; mem_done = 1'b0;
    wait_grant(10, ok);
    for (int c = 0; c < SC + 3; c++) tick();
    chk("t5_busy", 32'(busy), 32'd1);
    do_reset();
    chk("t5_gnt0", 32'(gnt), 32'd0);
    req = 4'b1111; mem_done = 1'b1;
    wait_grant(10, ok);
    chk("t5_core0", 32'(proc_ID), 32'd0);
    req = '0;
    wait_idle(20);

    // Memory never completes.
    do_reset();
    req = 4'b0001; req_type = 8'h00; mem_done = 1'b0;
    wait_grant(10, ok);
    for (int c = 0; c < SC + 1; c++) tick();
    req = '0;
    n = 0; t_d = -1;
    for (int c = 1; c <= 300 && t_d < 0; c++) begin
      tick();
      if (err) begin t_d = c; n = int'(txn_done); end
    end
`ifdef BUS_ARB_TIMEOUT_EN
    chk("t6_err_time", 32'(t_d), 32'(TMO));
    chk("t6_err_done", 32'(n), 32'd1);
`else
    chk("t6_no_err", 32'(t_d), 32'hffff_ffff);
    chk("t6_stuck", 32'(busy), 32'd1);
`endif
    do_reset();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      req      = 4'($urandom);
      req_type = 8'($urandom);
      mem_done = ($urandom_range(3) == 0);
      if ($urandom_range(199) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
